stash_sequencer: RTL and testbench
==================================

Name: stash_sequencer

Overview:
- Control block that drives the 8-bit sample stash (DEPTH entries, circular write and read pointers).
- Converts single-cycle user/stopwatch request pulses into the stash's sample_in_valid and next_sample strobes.
- Mirrors the stash pointers so browsing cycles only over stored entries.
- Adds an auto-scroll mode that advances the exposed sample every TICK cycles.

Parameters:
DEPTH, 5, number of stash entries; must equal the stash's DEPTH.
TICK, 50_000_000, auto-advance period in clk cycles (0.5 s at 100 MHz); must be >= 2.
PTR_W, $clog2(DEPTH), localparam, read index width.
TMR_W, $clog2(TICK), localparam, tick counter width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset. Also drives the stash reset so both agree after reset.
sample_req  in  1  one-cycle pulse: capture current sample.
next_req  in  1  one-cycle pulse: expose next stored sample.
auto_en  in  1  level: auto-scroll enable.
sample_in_valid  out  1  registered strobe to the stash.
next_sample  out  1  registered strobe to the stash; one read-pointer step per high cycle.
count  out  PTR_W+1  stored entries, 0..DEPTH, saturating.
read_idx  out  PTR_W  mirror of the stash read pointer.
busy  out  1  high while in WRAP.

Behaviour:
- Reset (reset=0, async): state=IDLE; sample_in_valid=0, next_sample=0, count=0, read_idx=0, busy=0; tick counter=TICK-1.
- Capture path, independent of the FSM and accepted in every state:
  - sample_req=1 at edge N -> sample_in_valid=1 during cycle N+1 only.
  - count increments at the same edge, saturating at DEPTH.
  - Back-to-back requests give back-to-back strobes.
- Advance request: next_req=1, or tick expiry in AUTO. If both occur in the same cycle, only one advance happens.
- Advance with count=0: ignored, no strobe.
- Simple advance, when count==DEPTH or read_idx+1 < count:
  - next_sample=1 for one cycle, starting the cycle after the request.
  - read_idx <= (read_idx+1) mod DEPTH.
- Wrap advance, when count<DEPTH and read_idx+1 >= count:
  - Enter WRAP.
  - next_sample held high for exactly DEPTH-read_idx consecutive cycles.
  - read_idx steps each cycle, ending at 0.
- Counts for count/read_idx use the values registered before the request edge; a same-cycle sample_req does not affect the decision.
- FSM states IDLE, AUTO, WRAP:
  - IDLE -> AUTO when auto_en=1 and count>=2; tick counter reloads to TICK-1.
  - AUTO -> IDLE when auto_en=0 or count<2.
  - AUTO tick counter decrements each cycle. At 0 it issues an advance and reloads TICK-1.
  - A manual next_req in AUTO also reloads the tick counter.
  - IDLE/AUTO -> WRAP on a wrap advance.
  - WRAP -> AUTO if auto_en=1, else IDLE, on the cycle after the final pulse.
- In WRAP:
  - busy=1.
  - next_req is dropped (not queued).
  - The tick counter is frozen.
  - sample_req is still serviced.
- read_idx may never equal or exceed count after a completed advance when count<DEPTH.
- Reset mid-WRAP aborts immediately: next_sample drops asynchronously, and all state returns to reset values.
- Outputs are registered only; there are no combinational input-to-output paths.

Test Plan:
1. Reset, then sample_req pulses at cycles 2, 3, 7 -> sample_in_valid high exactly in cycles 3, 4, 8; count=3; read_idx=0.
2. count=3, read_idx=0, DEPTH=5:
   - Two next_req pulses -> read_idx 1 then 2, one-cycle next_sample each.
   - Third next_req -> WRAP: next_sample and busy high 3 consecutive cycles, read_idx 3, 4, 0.
   - A next_req during WRAP is ignored.
3. After reset, count=0: next_req and auto_en=1 -> next_sample never asserts; state stays IDLE.
4. Seven sample_req pulses -> count saturates at 5. With read_idx=4, next_req gives a single next_sample pulse and read_idx=0 (no WRAP).
5. TICK=4, count=2, auto_en=1:
   - next_sample pulses every 4 cycles; read_idx alternates 1, 0 through WRAP.
   - A next_req mid-period advances and restarts the 4-cycle interval.
6. Reset pulled low during cycle 2 of a 4-cycle WRAP -> next_sample and busy drop without a clock edge; count=0, read_idx=0; the stash pointer check agrees after release.

Source files
------------

// File: rtl/stash_sequencer.sv
// Sequencer for the 8-bit sample stash: turns request pulses into stash strobes,
// mirrors the stash pointers and adds a timed auto-scroll through stored samples.
module stash_sequencer #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned TICK  = 50_000_000,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned TMR_W = $clog2(TICK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_req,
    input  logic             next_req,
    input  logic             auto_en,
    output logic             sample_in_valid,
    output logic             next_sample,
    output logic [PTR_W:0]   count,
    output logic [PTR_W-1:0] read_idx,
    output logic             busy
);

    localparam logic [PTR_W:0]   CountMax   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CountOne   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CountTwo   = (PTR_W + 1)'(2);
    localparam logic [PTR_W-1:0] IdxLast    = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] IdxOne     = PTR_W'(1);
    localparam logic [TMR_W-1:0] TickReload = TMR_W'(TICK - 1);
    localparam logic [TMR_W-1:0] TickOne    = TMR_W'(1);

    typedef enum logic [1:0] {StIdle, StAuto, StWrap} state_e;

    state_e           state_q, state_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] read_idx_q, read_idx_d;
    logic [TMR_W-1:0] tick_q, tick_d;
    logic             sample_in_valid_q, sample_in_valid_d;
    logic             next_sample_q, next_sample_d;

    logic [PTR_W-1:0] idx_inc;
    logic [PTR_W:0]   idx_plus1;
    logic             adv_req, adv_ok, adv_simple;

    always_comb begin
        idx_inc    = (read_idx_q == IdxLast) ? '0 : read_idx_q + IdxOne;
        idx_plus1  = {1'b0, read_idx_q} + CountOne;
        // Manual and tick requests in the same cycle merge into one advance.
        adv_req    = (state_q == StIdle && next_req) ||
                     (state_q == StAuto && (next_req || tick_q == '0));
        adv_ok     = adv_req && (count_q != '0);
        adv_simple = (count_q == CountMax) || (idx_plus1 < count_q);
    end

    always_comb begin
        state_d           = state_q;
        count_d           = count_q;
        read_idx_d        = read_idx_q;
        tick_d            = tick_q;
        sample_in_valid_d = sample_req;
        next_sample_d     = 1'b0;

        if (sample_req && count_q != CountMax) begin
            count_d = count_q + CountOne;
        end

        if (adv_ok) begin
            next_sample_d = 1'b1;
            read_idx_d    = idx_inc;
        end

        case (state_q)
            StIdle: begin
                if (adv_ok && !adv_simple) begin
                    state_d = StWrap;
                end else if (auto_en && count_q >= CountTwo) begin
                    state_d = StAuto;
                    tick_d  = TickReload;
                end
            end
            StAuto: begin
                tick_d = adv_req ? TickReload : tick_q - TickOne;
                if (adv_ok && !adv_simple) begin
                    state_d = StWrap;
                end else if (!auto_en || count_q < CountTwo) begin
                    state_d = StIdle;
                end
            end
            StWrap: begin
                // The final wrap step lands on 0; leave on the following edge.
                if (read_idx_q == '0) begin
                    state_d = auto_en ? StAuto : StIdle;
                end else begin
                    next_sample_d = 1'b1;
                    read_idx_d    = idx_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= StIdle;
            count_q           <= '0;
            read_idx_q        <= '0;
            tick_q            <= TickReload;
            sample_in_valid_q <= 1'b0;
            next_sample_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            read_idx_q        <= read_idx_d;
            tick_q            <= tick_d;
            sample_in_valid_q <= sample_in_valid_d;
            next_sample_q     <= next_sample_d;
        end
    end

    assign sample_in_valid = sample_in_valid_q;
    assign next_sample     = next_sample_q;
    assign count           = count_q;
    assign read_idx        = read_idx_q;
    assign busy            = (state_q == StWrap);

endmodule

// File: tb/tb_stash_sequencer.sv
// Directed bench for stash_sequencer with DEPTH=5 and a short TICK=4 auto period.
module tb_stash_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_req = 1'b0;
    logic       next_req = 1'b0;
    logic       auto_en = 1'b0;
    logic       sample_in_valid;
    logic       next_sample;
    logic [3:0] count;
    logic [2:0] read_idx;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // Stash read pointer model: one step per strobe, cleared by the shared reset.
    logic [2:0] stash_rd;

    int ns_tab[1:22]   = '{0,0,0,0,1,0,0,0,1,1,1,1,0,0,1,0,0,0,1,1,1,1};
    int idx_tab[1:22]  = '{0,0,0,0,1,1,1,1,2,3,4,0,0,0,1,1,1,1,2,3,4,0};
    int busy_tab[1:22] = '{0,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,0,0,1,1,1,1};

    stash_sequencer #(
        .DEPTH(5),
        .TICK (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_req     (sample_req),
        .next_req       (next_req),
        .auto_en        (auto_en),
        .sample_in_valid(sample_in_valid),
        .next_sample    (next_sample),
        .count          (count),
        .read_idx       (read_idx),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stash_rd <= 3'd0;
        end else if (next_sample) begin
            stash_rd <= (stash_rd == 3'd4) ? 3'd0 : stash_rd + 3'd1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sample_req = 1'b0;
        next_req = 1'b0;
        auto_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic pulse_next();
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values while reset is held low.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_siv", int'(sample_in_valid), 0);
        check("rst_ns", int'(next_sample), 0);
        check("rst_count", int'(count), 0);
        check("rst_idx", int'(read_idx), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: capture pulses at cycles 2, 3, 7.
        for (int c = 0; c < 10; c++) begin
            sample_req = (c == 2 || c == 3 || c == 7);
            tick();
            sample_req = 1'b0;
            check($sformatf("t1_siv_c%0d", c + 1), int'(sample_in_valid),
                  (c == 2 || c == 3 || c == 7) ? 1 : 0);
        end
        check("t1_count", int'(count), 3);
        check("t1_idx", int'(read_idx), 0);

        // 2: two simple advances, then a 3-cycle wrap with a dropped request.
        pulse_next();
        check("t2_ns_a", int'(next_sample), 1);
        check("t2_idx_a", int'(read_idx), 1);
        tick();
        check("t2_ns_a_off", int'(next_sample), 0);
        pulse_next();
        check("t2_ns_b", int'(next_sample), 1);
        check("t2_idx_b", int'(read_idx), 2);
        tick();
        check("t2_ns_b_off", int'(next_sample), 0);
        pulse_next();
        check("t2_w1_ns", int'(next_sample), 1);
        check("t2_w1_busy", int'(busy), 1);
        check("t2_w1_idx", int'(read_idx), 3);
        pulse_next();
        check("t2_w2_ns", int'(next_sample), 1);
        check("t2_w2_busy", int'(busy), 1);
        check("t2_w2_idx", int'(read_idx), 4);
        tick();
        check("t2_w3_ns", int'(next_sample), 1);
        check("t2_w3_busy", int'(busy), 1);
        check("t2_w3_idx", int'(read_idx), 0);
        tick();
        check("t2_end_ns", int'(next_sample), 0);
        check("t2_end_busy", int'(busy), 0);
        tick();
        check("t2_drop_ns", int'(next_sample), 0);
        check("t2_drop_idx", int'(read_idx), 0);
        check("t2_stash_ptr", int'(stash_rd), 0);

        // 3: empty stash ignores advances and auto mode.
        do_reset();
        auto_en = 1'b1;
        pulse_next();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_ns_%0d", k), int'(next_sample), 0);
            check($sformatf("t3_busy_%0d", k), int'(busy), 0);
            tick();
        end
        auto_en = 1'b0;
        check("t3_idx", int'(read_idx), 0);

        // 4: count saturates; full-stash advance from index 4 wraps without WRAP.
        for (int k = 0; k < 7; k++) begin
            sample_req = 1'b1;
            tick();
            check($sformatf("t4_siv_%0d", k), int'(sample_in_valid), 1);
            check($sformatf("t4_count_%0d", k), int'(count), (k < 5) ? k + 1 : 5);
        end
        sample_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pulse_next();
            tick();
        end
        check("t4_idx4", int'(read_idx), 4);
        pulse_next();
        check("t4_ns", int'(next_sample), 1);
        check("t4_idx0", int'(read_idx), 0);
        check("t4_busy", int'(busy), 0);
        tick();
        check("t4_ns_off", int'(next_sample), 0);
        check("t4_busy_off", int'(busy), 0);

        // 5: auto-scroll with two entries, plus a manual advance that restarts the period.
        do_reset();
        sample_req = 1'b1;
        tick();
        tick();
        sample_req = 1'b0;
        auto_en = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            next_req = (k == 15);
            tick();
            next_req = 1'b0;
            check($sformatf("t5_ns_k%0d", k), int'(next_sample), ns_tab[k]);
            check($sformatf("t5_idx_k%0d", k), int'(read_idx), idx_tab[k]);
            check($sformatf("t5_busy_k%0d", k), int'(busy), busy_tab[k]);
        end
        tick();
        check("t5_exit_ns", int'(next_sample), 0);
        check("t5_exit_busy", int'(busy), 0);
        check("t5_stash_ptr", int'(stash_rd), 0);
        auto_en = 1'b0;

        // 6: asynchronous reset in the second cycle of a 4-cycle wrap.
        do_reset();
        sample_req = 1'b1;
        tick();
        tick();
        sample_req = 1'b0;
        pulse_next();
        tick();
        check("t6_idx1", int'(read_idx), 1);
        pulse_next();
        check("t6_w1_busy", int'(busy), 1);
        check("t6_w1_idx", int'(read_idx), 2);
        tick();
        check("t6_w2_ns", int'(next_sample), 1);
        check("t6_w2_idx", int'(read_idx), 3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_ns", int'(next_sample), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_count", int'(count), 0);
        check("t6_async_idx", int'(read_idx), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        check("t6_post_ns", int'(next_sample), 0);
        check("t6_post_idx", int'(read_idx), 0);
        check("t6_stash_ptr", int'(stash_rd), 0);
        check("t6_post_count", int'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
